// File: rtl/decrypt_pipe_shift.sv
// Caesar-shift decrypt pipeline: classify/one-hot, rotate by key, decode back to ASCII.
// Latency 3 cycles from acceptance to dout, one byte per cycle when unstalled.
// Global stall: all stages hold while dout is valid and ready_in is low; ready_out mirrors advance.
module decrypt_pipe_shift #(
    parameter logic [4:0] KEY_RST = 5'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_load,
    input  logic [4:0]  key_in,
    input  logic        en,
    input  logic [7:0]  din,
    input  logic        mode,
    input  logic        shift_en,
    output logic        ready_out,
    input  logic        ready_in,
    output logic        en_out,
    output logic [7:0]  dout,
    output logic [15:0] out_cnt
);

    logic [4:0]  key_q;

    logic        v1, rot1, up1;
    logic [25:0] oh1;
    logic [7:0]  byte1;
    logic [4:0]  key1;

    logic        v2, rot2, up2;
    logic [25:0] oh2;
    logic [7:0]  byte2;

    logic        v3;
    logic        advance;

    logic        is_upper, is_lower, is_alpha;
    logic [4:0]  idx_d;
    logic [25:0] oh_d;
    logic [25:0] oh_rot;
    logic [4:0]  idx3;
    logic [7:0]  dec;

    assign advance   = ready_in | ~v3;
    assign ready_out = rst | advance;
    assign en_out    = v3;

    // 'A'..'Z' and 'a'..'z' both have low five bits 1..26, so one subtract gives the index.
    always_comb begin
        is_upper = (din >= 8'd65) && (din <= 8'd90);
        is_lower = (din >= 8'd97) && (din <= 8'd122);
        is_alpha = is_upper | is_lower;
        idx_d    = din[4:0] - 5'd1;
        oh_d     = is_alpha ? (26'd1 << idx_d) : 26'd0;
    end

    // Rotate right by key1: output bit j takes input bit (j + key) mod 26.
    always_comb begin
        logic [5:0] t;
        oh_rot = '0;
        for (int j = 0; j < 26; j++) begin
            t = 6'(j) + {1'b0, key1};
            if (t >= 6'd26)
                t = t - 6'd26;
            oh_rot[j] = oh1[t[4:0]];
        end
    end

    always_comb begin
        idx3 = '0;
        for (int j = 0; j < 26; j++) begin
            if (oh2[j])
                idx3 = 5'(j);
        end
        if (rot2)
            dec = (up2 ? 8'd65 : 8'd97) + {3'b000, idx3};
        else
            dec = byte2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= KEY_RST;
        end else if (key_load) begin
            key_q <= (key_in >= 5'd26) ? (key_in - 5'd26) : key_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            rot1  <= 1'b0;
            up1   <= 1'b0;
            oh1   <= '0;
            byte1 <= '0;
            key1  <= '0;
            v2    <= 1'b0;
            rot2  <= 1'b0;
            up2   <= 1'b0;
            oh2   <= '0;
            byte2 <= '0;
            v3    <= 1'b0;
            dout  <= '0;
        end else if (advance) begin
            v1 <= en;
            if (en) begin
                rot1  <= mode & shift_en & is_alpha;
                up1   <= is_upper;
                oh1   <= oh_d;
                byte1 <= din;
                key1  <= key_q;
            end
            v2 <= v1;
            if (v1) begin
                rot2  <= rot1;
                up2   <= up1;
                oh2   <= oh_rot;
                byte2 <= byte1;
            end
            v3 <= v2;
            if (v2)
                dout <= dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_cnt <= '0;
        else if (v3 && ready_in)
            out_cnt <= out_cnt + 16'd1;
    end

endmodule

// File: tb/tb_decrypt_pipe_shift.sv
// Directed bench for decrypt_pipe_shift: latency, key wrap, pass-through, stall, key timing, reset flush.
module tb_decrypt_pipe_shift;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load;
    logic [4:0]  key_in;
    logic        en;
    logic [7:0]  din;
    logic        mode;
    logic        shift_en;
    logic        ready_out;
    logic        ready_in;
    logic        en_out;
    logic [7:0]  dout;
    logic [15:0] out_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    decrypt_pipe_shift #(.KEY_RST(5'd3)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .en(en), .din(din), .mode(mode), .shift_en(shift_en),
        .ready_out(ready_out), .ready_in(ready_in), .en_out(en_out),
        .dout(dout), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && en_out && ready_in)
            q.push_back(dout);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc(input logic e, input logic [7:0] b, input logic m, input logic s,
                       input logic kl, input logic [4:0] ki);
        en = e; din = b; mode = m; shift_en = s; key_load = kl; key_in = ki;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        en = 1'b0; key_load = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; key_load = 1'b0; ready_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic drain(input int n, input string name);
        int k = 0;
        while (q.size() < n && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (q.size() != n) begin
            errors++;
            $display("FAIL %s count: got %0d outputs, expected %0d", name, q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; din = 8'h44; mode = 1'b1; shift_en = 1'b1;
        ready_in = 1'b0; key_load = 1'b1; key_in = 5'd10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL reset en_out: got %b expected 0", en_out); end
        checks++; if (out_cnt !== 16'd0) begin errors++; $display("FAIL reset out_cnt: got %0d expected 0", out_cnt); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset dout: got %h expected 00", dout); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset ready_out: got %b expected 1", ready_out); end
        rst = 1'b0; ready_in = 1'b1;
        q.delete();
        idle(6);
        checks++; if (q.size() != 0) begin errors++; $display("FAIL reset accepted byte: got %0d outputs expected 0", q.size()); end
    endtask

    task automatic test_basic();
        q.delete();
        ready_in = 1'b1;
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL basic ready_out: got %b expected 1", ready_out); end
        cyc(1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 5'd0);
        en = 1'b0;
        checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL basic early en_out c1: got %b expected 0", en_out); end
        @(posedge clk); #1;
        checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL basic early en_out c2: got %b expected 0", en_out); end
        @(posedge clk); #1;
        checks++; if (en_out !== 1'b1) begin errors++; $display("FAIL basic en_out c3: got %b expected 1", en_out); end
        checks++; if (dout !== 8'h41) begin errors++; $display("FAIL basic dout: got %h expected 41", dout); end
        @(posedge clk); #1;
        checks++; if (out_cnt !== 16'd1) begin errors++; $display("FAIL basic out_cnt: got %0d expected 1", out_cnt); end
        checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL basic en_out c4: got %b expected 0", en_out); end
    endtask

    task automatic test_wrap();
        logic [7:0] vin [4]  = '{8'h62, 8'h41, 8'h61, 8'h5A};
        logic [7:0] vexp [4] = '{8'h79, 8'h58, 8'h78, 8'h57};
        q.delete();
        ready_in = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd29);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, vin[i], 1'b1, 1'b1, 1'b0, 5'd0);
        idle(1);
        drain(4, "wrap");
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            checks++;
            if (q[i] !== vexp[i]) begin errors++; $display("FAIL wrap byte %0d: got %h expected %h", i, q[i], vexp[i]); end
        end
    endtask

    task automatic test_passthrough();
        logic [7:0] vin [7] = '{8'h35, 8'h44, 8'h44, 8'h40, 8'h5B, 8'h60, 8'h7B};
        logic       vm  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       vs  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        q.delete();
        ready_in = 1'b1;
        for (int i = 0; i < 7; i++)
            cyc(1'b1, vin[i], vm[i], vs[i], 1'b0, 5'd0);
        idle(1);
        drain(7, "passthrough");
        for (int i = 0; i < 7 && i < q.size(); i++) begin
            checks++;
            if (q[i] !== vin[i]) begin errors++; $display("FAIL passthrough byte %0d: got %h expected %h", i, q[i], vin[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] msg [5]  = '{8'h4B, 8'h48, 8'h4F, 8'h4F, 8'h52};
        logic [7:0] vexp [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        int idx = 0;
        int stall_left = 0;
        int stall_seen = 0;
        bit started = 0;
        logic accepted;
        do_reset();
        for (int c = 0; c < 40 && q.size() < 5; c++) begin
            if (en_out && !started) begin
                started = 1;
                stall_left = 2;
            end
            ready_in = (stall_left > 0) ? 1'b0 : 1'b1;
            en = (idx < 5); din = (idx < 5) ? msg[idx] : 8'h00;
            mode = 1'b1; shift_en = 1'b1; key_load = 1'b0;
            #1;
            if (stall_left > 0) begin
                stall_seen++;
                checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL stall ready_out: got %b expected 0", ready_out); end
                checks++; if (en_out !== 1'b1 || dout !== 8'h48) begin errors++; $display("FAIL stall hold: got en_out=%b dout=%h expected 1/48", en_out, dout); end
                stall_left--;
            end
            accepted = en && ready_out;
            @(posedge clk); #1;
            if (accepted) idx++;
        end
        ready_in = 1'b1;
        idle(1);
        checks++; if (stall_seen != 2) begin errors++; $display("FAIL stall cycles: got %0d expected 2", stall_seen); end
        checks++; if (q.size() != 5) begin errors++; $display("FAIL hello count: got %0d expected 5", q.size()); end
        for (int i = 0; i < 5 && i < q.size(); i++) begin
            checks++;
            if (q[i] !== vexp[i]) begin errors++; $display("FAIL hello byte %0d: got %h expected %h", i, q[i], vexp[i]); end
        end
        checks++; if (out_cnt !== 16'd5) begin errors++; $display("FAIL hello out_cnt: got %0d expected 5", out_cnt); end
    endtask

    task automatic test_key_change();
        logic [7:0] vexp [4] = '{8'h42, 8'h44, 8'h44, 8'h5A};
        q.delete();
        ready_in = 1'b1;
        cyc(1'b1, 8'h45, 1'b1, 1'b1, 1'b0, 5'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd1);
        cyc(1'b1, 8'h45, 1'b1, 1'b1, 1'b0, 5'd0);
        cyc(1'b1, 8'h45, 1'b1, 1'b1, 1'b1, 5'd5);
        cyc(1'b1, 8'h45, 1'b1, 1'b1, 1'b0, 5'd0);
        idle(1);
        drain(4, "keychange");
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            checks++;
            if (q[i] !== vexp[i]) begin errors++; $display("FAIL keychange byte %0d: got %h expected %h", i, q[i], vexp[i]); end
        end
    endtask

    task automatic test_midstream_reset();
        q.delete();
        ready_in = 1'b0;
        cyc(1'b1, 8'h4B, 1'b1, 1'b1, 1'b0, 5'd0);
        cyc(1'b1, 8'h48, 1'b1, 1'b1, 1'b0, 5'd0);
        cyc(1'b1, 8'h4F, 1'b1, 1'b1, 1'b0, 5'd0);
        en = 1'b0;
        checks++; if (en_out !== 1'b1 || ready_out !== 1'b0) begin errors++; $display("FAIL inflight: got en_out=%b ready_out=%b expected 1/0", en_out, ready_out); end
        rst = 1'b1; key_load = 1'b1; key_in = 5'd10; en = 1'b1; din = 8'h58;
        #1;
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rst ready_out: got %b expected 1", ready_out); end
        @(posedge clk); #1;
        rst = 1'b0; key_load = 1'b0; en = 1'b0; ready_in = 1'b1;
        checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL flush en_out: got %b expected 0", en_out); end
        checks++; if (out_cnt !== 16'd0) begin errors++; $display("FAIL flush out_cnt: got %0d expected 0", out_cnt); end
        idle(8);
        checks++; if (q.size() != 0) begin errors++; $display("FAIL flushed byte seen: got %0d outputs expected 0", q.size()); end
        cyc(1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 5'd0);
        idle(1);
        drain(1, "postreset");
        if (q.size() > 0) begin
            checks++;
            if (q[0] !== 8'h41) begin errors++; $display("FAIL postreset key: got %h expected 41", q[0]); end
        end
        checks++; if (out_cnt !== 16'd1) begin errors++; $display("FAIL postreset out_cnt: got %0d expected 1", out_cnt); end
    endtask

    initial begin
        rst = 1'b1; key_load = 1'b0; key_in = 5'd0; en = 1'b0; din = 8'h00;
        mode = 1'b0; shift_en = 1'b0; ready_in = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_wrap();
        test_passthrough();
        test_backpressure();
        test_key_change();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decrypt_pipe_shift.md
DECRYPT_PIPE_SHIFT -- requirements
Module: decrypt_pipe_shift

Interface
REQ-001 Parameter KEY_RST, default 3: 5-bit key value loaded by reset; legal range 0..25.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 key_load  in  1  key_in is captured when high.
REQ-005 key_in  in  5  rotation key, 0..31; reduced mod 26 on capture.
REQ-006 en  in  1  input byte valid.
REQ-007 din  in  8  ciphertext byte (ASCII).
REQ-008 mode  in  1  1 = decrypt, 0 = pass-through; sampled with the byte.
REQ-009 shift_en  in  1  1 = apply rotation, 0 = pass-through; sampled with the byte.
REQ-010 ready_out  out  1  block accepts din this cycle.
REQ-011 ready_in  in  1  downstream accepts dout this cycle.
REQ-012 en_out  out  1  dout valid.
REQ-013 dout  out  8  plaintext byte.
REQ-014 out_cnt  out  16  count of completed output transfers.

Function
REQ-015 Pipeline SHALL have 3 stages: S1 classify and one-hot encode; S2 rotate; S3 decode to ASCII; each stage holds a valid bit.
REQ-016 advance = ready_in OR NOT S3 valid; all stages SHALL shift together only when advance=1, otherwise hold.
REQ-017 ready_out SHALL equal advance; a byte is accepted when en AND ready_out.
REQ-018 Latency: an accepted byte SHALL appear on dout with en_out=1 exactly 3 cycles later with no stall; throughput 1 byte/cycle.
REQ-019 en_out and dout SHALL hold stable while en_out=1 and ready_in=0.
REQ-020 S1: upper = din in 65..90, lower = din in 97..122; one-hot index = din-65 or din-97, 26 bits.
REQ-021 S1: byte SHALL be marked non-rotating if mode=0, shift_en=0, or not alpha; it then passes unchanged to dout.
REQ-022 Key register SHALL store key_in mod 26 (key_in>=26 -> key_in-26) on the cycle key_load=1.
REQ-023 Each accepted byte SHALL carry the key value present on its acceptance cycle; a key_load on that same cycle does not affect it, only later bytes.
REQ-024 S2: one-hot SHALL be rotated right by key, index' = (index - key) mod 26, wrapping 'a' to 'z' side.
REQ-025 S3: dout = index' + 65 if upper, index' + 97 if lower, else original byte.
REQ-026 Bubbles (S1/S2 empty) SHALL NOT be collapsed during a stall; the global advance rule applies.
REQ-027 out_cnt SHALL increment by 1 on each cycle en_out AND ready_in, wrapping 0xFFFF to 0.
REQ-028 Byte order SHALL be preserved; no byte dropped or duplicated under any ready_in pattern.

Reset
REQ-029 On rst=1 at a clock edge: all stage valids, en_out, dout, and out_cnt SHALL be 0, and key SHALL be KEY_RST.
REQ-030 Reset mid-stream SHALL discard in-flight bytes; en_out=0 from the cycle after the reset edge.
REQ-031 While rst=1, ready_out SHALL be 1 (S3 empty) but no byte is accepted.
REQ-032 key_load during rst=1 SHALL be ignored.

Verification
REQ-033 After reset (key=3), send 0x44 'D', mode=1, shift_en=1, ready_in=1 -> dout=0x41 'A', en_out high exactly 3 cycles after acceptance; out_cnt=1.
REQ-034 Wrap case: key_load with key_in=29 (effective 3), then send 0x62 'b' -> dout=0x79 'y'; send 0x41 'A' -> dout=0x58 'X'.
REQ-035 Pass-through: 0x35 '5' -> 0x35; 'D' with mode=0 -> 0x44; 'D' with shift_en=0 -> 0x44.
REQ-036 Backpressure: stream "KHOOR" with key 3 while ready_in is low for 2 cycles once the first byte reaches S3 -> ready_out=0 during the stall, output is exactly "HELLO" in order, out_cnt=5.
REQ-037 Key change mid-stream: accept 'E' (key 3), key_load key_in=1 on the next cycle, then accept 'E' -> outputs 'B' then 'D'.
REQ-038 Assert rst for 1 cycle with 3 bytes in flight -> en_out=0 afterwards, out_cnt=0, key=3, and no flushed byte ever appears.
